pipeline_hazard_scheduler: RTL and testbench
============================================

Name: pipeline_hazard_scheduler

Overview:
- Hazard and sequencing controller for the 5-stage ARM-style pipeline (F/D/E/M/W).
- Produces stall, flush and forwarding controls from register addresses and the control bits the pipeline already carries.
- Schedules a multi-cycle multiplier:
  - holds the MUL instruction in Decode and bubbles Execute until the multiplier finishes;
  - then releases the MUL into Execute.

Parameters:
MUL_LATENCY, 4, busy cycles of the multiplier after mul_start (legal range 1..15)
CNT_W, 4, counter width; must satisfy 2^CNT_W > MUL_LATENCY

Ports:
sys_clk  in  1  clock, rising edge
sys_rst_n  in  1  asynchronous reset, active-high (1 = reset)
RA1D  in  4  Decode read address 1
RA2D  in  4  Decode read address 2
RA1E  in  4  Execute source register 1
RA2E  in  4  Execute source register 2
WA3E  in  4  Execute destination register
WA3M  in  4  Memory destination register
WA3W  in  4  Writeback destination register
RegWriteM  in  1  Memory-stage register write enable
RegWriteW  in  1  Writeback-stage register write enable
MemtoRegE  in  1  Execute instruction is a load
BranchTakenE  in  1  branch resolved taken in Execute
PCWrPendingF  in  1  PC-writing instruction in D, E or M
PCSrcW  in  1  PC write in Writeback
Mul_CtrlD  in  1  Decode instruction is a multiply
StallF  out  1  hold PC / Fetch register
StallD  out  1  hold F/D register
FlushD  out  1  clear F/D register
FlushE  out  1  clear D/E register (insert bubble)
ForwardAE  out  2  SrcA select: 00 regfile, 01 ResultW, 10 ALUResultM
ForwardBE  out  2  SrcB select, same encoding
mul_start  out  1  one-cycle pulse launching the multiplier
mul_busy  out  1  multiplier FSM in BUSY
mul_done  out  1  one-cycle pulse: result valid, MUL may advance

Behaviour:
- Reset (sys_rst_n=1, async):
  - state=IDLE, counter=0.
  - Every output is forced to 0 while reset is held, including the combinational ones.
- Forwarding (combinational, per operand X in {1,2}):
  - 10 if RAXE==WA3M and RegWriteM;
  - else 01 if RAXE==WA3W and RegWriteW;
  - else 00.
  - Memory stage wins when both stages match.
- Load-use: ldrStall = MemtoRegE & (RA1D==WA3E | RA2D==WA3E).
- FSM states: IDLE, BUSY, DONE.
- Transitions:
  - IDLE -> BUSY when Mul_CtrlD & ~ldrStall & ~FlushD. On that cycle: mul_start=1, counter loads MUL_LATENCY-1.
  - BUSY: counter decrements each cycle. At counter==0 -> DONE.
  - DONE: mul_done=1 for exactly one cycle, mulStall=0 so the MUL enters Execute, then -> IDLE unconditionally. DONE never re-issues even though Mul_CtrlD is still high this cycle.
- mulStall = (IDLE & Mul_CtrlD & ~FlushD & ~ldrStall) | BUSY.
- mul_busy = (state==BUSY).
- Outputs:
  - StallF = ldrStall | PCWrPendingF | mulStall
  - StallD = ldrStall | mulStall
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE
  - FlushE = ldrStall | BranchTakenE | mulStall
- MUL timing: MUL in D at cycle t (IDLE) reaches Execute at the edge ending cycle t+MUL_LATENCY+1.
- Wrong-path MUL: a MUL in Decode while BranchTakenE, PCWrPendingF or PCSrcW is 1 is not issued (FlushD kills it). It issues on a later cycle if it is still present after the flush clears.
- Load-use on a MUL: ldrStall has priority. The MUL waits in IDLE and issues on the first cycle ldrStall=0.
- During BUSY/DONE, Execute holds bubbles, so BranchTakenE cannot assert from the MUL's own slot. If it does (older instruction resolved late), the FSM completes its count unchanged.
- Reset mid-BUSY: immediate return to IDLE; mul_busy/mul_start/mul_done drop asynchronously; counter cleared.
- MUL_LATENCY=1: BUSY lasts exactly one cycle.

Test Plan:
- Forwarding priority: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10. Then RegWriteM=0 -> ForwardAE=01. With RA2E=5 and no match -> ForwardBE=00.
- Load-use: MemtoRegE=1, WA3E=2, RA2D=2 -> StallF=StallD=FlushE=1 for one cycle, FlushD=0.
- MUL, MUL_LATENCY=4: Mul_CtrlD=1 at cycle 0 ->
  - mul_start=1 at cycle 0;
  - mul_busy=1 at cycles 1-4;
  - mul_done=1 at cycle 5;
  - StallD=1 at cycles 0-4, StallD=0 at cycle 5;
  - FlushE=1 at cycles 0-4;
  - no second mul_start at cycle 5.
- Branch kills MUL: Mul_CtrlD=1 and BranchTakenE=1 same cycle -> mul_start=0, FlushD=1, FlushE=1, state stays IDLE.
- Load-use before MUL: Mul_CtrlD=1 with ldrStall for one cycle -> mul_start delayed exactly one cycle.
- Async reset at 2nd BUSY cycle -> mul_busy=0 without clock edge. After release, Mul_CtrlD=1 -> fresh mul_start and full 4-cycle count.

Source files
------------

// File: rtl/pipeline_hazard_scheduler.sv
// Hazard/sequencing controller for the 5-stage pipeline: forwarding selects, load-use and
// branch stall/flush, and a small FSM that parks a MUL in Decode while the multiplier runs.
module pipeline_hazard_scheduler #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       BranchTakenE,
  input  logic       PCWrPendingF,
  input  logic       PCSrcW,
  input  logic       Mul_CtrlD,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       mul_start,
  output logic       mul_busy,
  output logic       mul_done
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mulState_t;

  mulState_t        state, nextState;
  logic [CNT_W-1:0] count;
  logic             ldrStall, flushRaw, mulIssue, mulStall;

  // Memory-stage producer is younger, so it takes priority over Writeback.
  function automatic logic [1:0] fwdSel(input logic [3:0] ra);
    if (ra == WA3M && RegWriteM)      return 2'b10;
    else if (ra == WA3W && RegWriteW) return 2'b01;
    else                              return 2'b00;
  endfunction

  assign ldrStall = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E));
  assign flushRaw = PCWrPendingF | PCSrcW | BranchTakenE;
  assign mulIssue = (state == IDLE) & Mul_CtrlD & ~ldrStall & ~flushRaw;
  assign mulStall = mulIssue | (state == BUSY);

  // NOTE: state-holding registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= nextState;
      if (mulIssue)
        count <= CNT_W'(MUL_LATENCY - 1);
      else if (state == BUSY && count != '0)
        count <= count - 1'b1;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    nextState = state;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    mul_start = 1'b0;
    mul_busy  = 1'b0;
    mul_done  = 1'b0;

    unique case (state)
      IDLE:    if (mulIssue) nextState = BUSY;
      BUSY:    if (count == '0) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase

    // Reset is asynchronous, so the combinational outputs are gated as well.
    if (!sys_rst_n) begin
      StallF    = ldrStall | PCWrPendingF | mulStall;
      StallD    = ldrStall | mulStall;
      FlushD    = flushRaw;
      FlushE    = ldrStall | BranchTakenE | mulStall;
      ForwardAE = fwdSel(RA1E);
      ForwardBE = fwdSel(RA2E);
      mul_start = mulIssue;
      mul_busy  = (state == BUSY);
      mul_done  = (state == DONE);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_scheduler.sv
// Scoreboard bench: stimulus pushes expected outputs from a cycle-count reference model,
// a negedge monitor pops and compares every cycle.
module tb_pipeline_hazard_scheduler;

  localparam int LAT = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, PCWrPendingF, PCSrcW, Mul_CtrlD;
  logic       StallF, StallD, FlushD, FlushE, mul_start, mul_busy, mul_done;
  logic [1:0] ForwardAE, ForwardBE;

  typedef struct packed {
    logic       rst;
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic       rwm, rww, memToReg, branch, pcWrPend, pcSrcW, mul;
  } stim_t;

  typedef struct packed {
    logic       stallF, stallD, flushD, flushE;
    logic [1:0] fwdA, fwdB;
    logic       start, busy, done;
  } resp_t;

  resp_t sbQ[$];
  int    nChecks = 0;
  int    nFail = 0;
  int    cyc = 0;
  int    mulLeft = 0;   // cycles until the MUL's Execute slot opens; 0 = no MUL in flight
  bit    lastIssue = 1'b0;
  bit    lastRst = 1'b1;

  pipeline_hazard_scheduler #(.MUL_LATENCY(LAT), .CNT_W(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .BranchTakenE(BranchTakenE), .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW),
    .Mul_CtrlD(Mul_CtrlD),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mul_start(mul_start), .mul_busy(mul_busy), .mul_done(mul_done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [1:0] refFwd(input logic [3:0] ra, input stim_t s);
    if (s.rwm && ra == s.wa3m) return 2'b10;
    if (s.rww && ra == s.wa3w) return 2'b01;
    return 2'b00;
  endfunction

  // One pipeline cycle: advance the model across the edge, drive inputs, queue the expectation.
  task automatic step(input stim_t s);
    resp_t e;
    bit    ldr, flushD, busy, issue;
    @(posedge sys_clk);
    if (lastRst) mulLeft = 0;
    else begin
      if (mulLeft > 0) mulLeft--;
      if (lastIssue) mulLeft = LAT + 1;
    end
    #1;
    sys_rst_n = s.rst;
    RA1D = s.ra1d; RA2D = s.ra2d; RA1E = s.ra1e; RA2E = s.ra2e;
    WA3E = s.wa3e; WA3M = s.wa3m; WA3W = s.wa3w;
    RegWriteM = s.rwm; RegWriteW = s.rww; MemtoRegE = s.memToReg;
    BranchTakenE = s.branch; PCWrPendingF = s.pcWrPend; PCSrcW = s.pcSrcW; Mul_CtrlD = s.mul;

    ldr    = s.memToReg && (s.ra1d == s.wa3e || s.ra2d == s.wa3e);
    flushD = s.pcWrPend || s.pcSrcW || s.branch;
    busy   = mulLeft >= 2;
    issue  = !s.rst && mulLeft == 0 && s.mul && !ldr && !flushD;
    e = '0;
    if (!s.rst) begin
      e.stallF = ldr || s.pcWrPend || issue || busy;
      e.stallD = ldr || issue || busy;
      e.flushD = flushD;
      e.flushE = ldr || s.branch || issue || busy;
      e.fwdA   = refFwd(s.ra1e, s);
      e.fwdB   = refFwd(s.ra2e, s);
      e.start  = issue;
      e.busy   = busy;
      e.done   = mulLeft == 1;
    end
    sbQ.push_back(e);
    lastIssue = issue;
    lastRst   = s.rst;
  endtask

  always @(negedge sys_clk) begin : monitor
    resp_t e, a;
    if (sbQ.size() != 0) begin
      e = sbQ.pop_front();
      a = '{StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, mul_start, mul_busy, mul_done};
      check("stall_flush", 32'(a[10:7]), 32'(e[10:7]));
      check("forward",     32'(a[6:3]),  32'(e[6:3]));
      check("mul_ctrl",    32'(a[2:0]),  32'(e[2:0]));
      cyc++;
    end
  end

  initial begin
    stim_t s;
    // Reset held with active hazards: every output must still read 0.
    s = '0; s.rst = 1'b1; s.branch = 1'b1; s.mul = 1'b1; s.rwm = 1'b1;
    repeat (2) step(s);

    // Forwarding priority, then Writeback-only match, operand B unmatched.
    s = '0; s.ra1e = 4'd3; s.wa3m = 4'd3; s.rwm = 1'b1; s.wa3w = 4'd3; s.rww = 1'b1;
    s.ra2e = 4'd5;
    step(s);
    s.rwm = 1'b0;
    step(s);

    // Load-use hazard for one cycle.
    s = '0; s.memToReg = 1'b1; s.wa3e = 4'd2; s.ra2d = 4'd2; s.ra1d = 4'd7;
    step(s);
    s = '0; step(s);

    // Full MUL: start, four busy cycles, done without re-issue.
    s = '0; s.mul = 1'b1;
    repeat (LAT + 2) step(s);
    s = '0; step(s);

    // Taken branch kills a MUL in Decode.
    s = '0; s.mul = 1'b1; s.branch = 1'b1;
    step(s);
    s = '0; step(s);

    // Load-use delays the MUL by exactly one cycle.
    s = '0; s.mul = 1'b1; s.memToReg = 1'b1; s.wa3e = 4'd4; s.ra1d = 4'd4; s.ra2d = 4'd1;
    step(s);
    s = '0; s.mul = 1'b1;
    repeat (LAT + 2) step(s);
    s = '0; step(s);

    // Asynchronous reset in the second BUSY cycle, then a fresh full-length MUL.
    s = '0; s.mul = 1'b1;
    repeat (2) step(s);
    s.rst = 1'b1;
    step(s);
    s.rst = 1'b0;
    repeat (LAT + 2) step(s);
    s = '0; step(s);

    // Randomised traffic: narrow register space to make address matches common.
    for (int i = 0; i < 3000; i++) begin
      s.rst      = ($urandom_range(0, 63) == 0);
      s.ra1d     = 4'($urandom_range(0, 3));
      s.ra2d     = 4'($urandom_range(0, 3));
      s.ra1e     = 4'($urandom_range(0, 3));
      s.ra2e     = 4'($urandom_range(0, 3));
      s.wa3e     = 4'($urandom_range(0, 3));
      s.wa3m     = 4'($urandom_range(0, 3));
      s.wa3w     = 4'($urandom_range(0, 3));
      s.rwm      = 1'($urandom_range(0, 1));
      s.rww      = 1'($urandom_range(0, 1));
      s.memToReg = ($urandom_range(0, 3) == 0);
      s.branch   = ($urandom_range(0, 7) == 0);
      s.pcWrPend = ($urandom_range(0, 9) == 0);
      s.pcSrcW   = ($urandom_range(0, 15) == 0);
      s.mul      = ($urandom_range(0, 9) < 6);
      step(s);
    end

    @(negedge sys_clk);
    #1;
    check("scoreboard_drained", 32'(sbQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule
